load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit of the RISC-V pipeline: it turns a load or store from EX/MEM into a single req/ack transaction on the data-memory port. For loads it byte-selects and sign/zero-extends the returned word into `data_read`, the load operand consumed by writeback. It stalls the pipeline while a transaction is outstanding and flags misaligned or illegal accesses without touching memory.

## Interface
- `WIDTH`, 32: datapath and address width; only 32 is supported, with 4 byte lanes.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `funct3`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  WIDTH  byte address, which is the ALU result.
- `store_data`  in  WIDTH  rs2 value, with the payload in the low bits.
- `stall`  out  1  holds the pipeline; the EX/MEM inputs stay stable while it is 1.
- `data_read`  out  WIDTH  extended load result, to writeback.
- `data_valid`  out  1  one-cycle strobe; `data_read` is updated this cycle.
- `access_fault`  out  1  misaligned or illegal-funct3 access was rejected.
- `dmem_req`  out  1  memory request, held until ack.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  WIDTH  word-aligned address, `{addr[WIDTH-1:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  WIDTH  lane-replicated store data.
- `dmem_rdata`  in  WIDTH  read word, valid with ack.
- `dmem_ack`  in  1  transaction complete.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE, no request:** with `mem_read|mem_write`=0, stay in IDLE.
- **IDLE, legal request:** register `dmem_req`=1, `dmem_we`=`mem_write`, address, byte enables and wdata, then go to WAIT.
- **IDLE, illegal request:** `access_fault`=1 (combinational), `stall`=0, no request issued, stay in IDLE, `data_read` unchanged. An access is illegal when:
  - a halfword access has `addr[0]`=1, or
  - a word access has `addr[1:0]`≠0, or
  - funct3 is 011/110/111, or
  - a store has `funct3[2]`=1.
- **WAIT:** hold all `dmem_*` outputs stable. On `dmem_ack`:
  - drop `dmem_req` at the next edge;
  - for a load, register the extended `dmem_rdata` into `data_read`;
  - go to RESP.
- **RESP:** `data_valid`=1 for a load (0 for a store), `stall`=0, always return to IDLE. A new request is never issued from RESP, because the inputs still show the completed instruction.
- **stall** = (IDLE & legal request) | WAIT.
- **Both mem_read and mem_write set:** the store wins; no load data is returned.
- **Store lanes:**
  - SB: be = `4'b0001 << addr[1:0]`, wdata = 4×byte.
  - SH: be = 0011 when `addr[1]`=0, otherwise 1100; wdata = 2×half.
  - SW: be = 1111.
- **Load be:** the same as the store be, for observability.
- **Load extension:** select the lane by `addr[1:0]`. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- **Ignored ack:** `dmem_ack` outside WAIT is ignored.
- **Timeout:** none; WAIT persists until ack.

## Timing
- **Reset values:** all outputs 0, `data_read`=0, state IDLE. Asserting `rst_n` mid-transaction drops `dmem_req` immediately, asynchronously; no retry is made after reset.
- **Minimum latency (ack in the first WAIT cycle):**
  - request seen in cycle 0 with `stall`=1;
  - `dmem_req`=1 in cycle 1;
  - RESP in cycle 2 with `data_valid`=1, `stall`=0.
- **Latency with slow ack:** 3 + N cycles for ack arriving N cycles late.
- **Back-to-back accesses:** issue at one per 3 cycles minimum. A new request can be seen in the cycle after RESP.
- **Combinational outputs:** `stall` and `access_fault` are combinational from the inputs and state. All `dmem_*` outputs, `data_read` and `data_valid` are registered.

## Structure
- **Shared package `riscv_pkg`:** the funct3 load/store constants (`F3_LB`…`F3_LHU`, `F3_SB`…`F3_SW`) and the `lsu_state_t` enum {IDLE, WAIT, RESP}.
- **Sub-module `load_extend`:** combinational. Inputs are `rdata`, `addr[1:0]` and `funct3`; output is the extended word. It is reused by the verification model.

## Test plan
- **LW:** LW `addr`=0x100, `dmem_rdata`=0xDEADBEEF with ack in the first WAIT cycle → `dmem_addr`=0x100, be=1111, `data_valid` in cycle 2, `data_read`=0xDEADBEEF, `stall` high for cycles 0–1 only.
- **LB / LBU:** LB `addr`=0x103 with rdata 0x80FF0000 → `data_read`=0xFFFFFF80. LBU at the same address → 0x00000080.
- **SH:** SH `addr`=0x202, `store_data`=0x1234ABCD → `dmem_addr`=0x200, be=1100, wdata=0xABCDABCD, `dmem_we`=1, `data_valid`=0.
- **Ack delay:** ack delayed 5 cycles → `dmem_*` stable throughout WAIT, `stall`=1 for 7 cycles, then RESP.
- **Misaligned:** LW `addr`=0x102 → `access_fault`=1, `dmem_req` stays 0, `stall`=0. Also funct3=011 with `mem_read` → `access_fault`=1.
- **Reset mid-transaction:** `rst_n` low during WAIT → `dmem_req`=0 immediately. After release the FSM is in IDLE with all outputs 0, and a late `dmem_ack` is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 load/store encodings and LSU state type
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed lane of a read word and sign/zero-extends it
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select then extension by access type
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LBU ? {24'b0, b} :
           funct3 == F3_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns an EX/MEM load/store into one req/ack data-memory transaction
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             stall,
  output logic [WIDTH-1:0] data_read,
  output logic             data_valid,
  output logic             access_fault,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack
);
  lsu_state_t state, state_n;
  logic req, bad, go, done;
  logic [3:0] be_n;
  logic [WIDTH-1:0] wdata_n, ext;
  load_extend u_ext (
    .rdata(dmem_rdata),
    .addr(addr[1:0]),
    .funct3(funct3),
    .data(ext)
  );
  // legality check, lane formatting, handshake decode and next state
  always_comb begin
    req = mem_read | mem_write;
    bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (mem_write && funct3[2]) ||
          (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    go = state == IDLE && req && !bad;
    done = state == WAIT && dmem_ack;
    access_fault = state == IDLE && req && bad;
    stall = go || state == WAIT;
    be_n = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
           funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
              funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    state_n = state == IDLE ? (go ? WAIT : IDLE) :
              state == WAIT ? (dmem_ack ? RESP : WAIT) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // memory port and load result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= 4'b0;
      dmem_wdata <= '0;
      data_read <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= done && !dmem_we;
      if (go) begin
        dmem_req <= 1'b1;
        dmem_we <= mem_write;
        dmem_addr <= {addr[WIDTH-1:2], 2'b00};
        dmem_be <= be_n;
        dmem_wdata <= wdata_n;
      end else if (done) begin
        dmem_req <= 1'b0;
        if (!dmem_we) data_read <= ext;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          delay;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] dr;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, dmem_ack = 1'b0;
  logic [2:0] funct3 = 3'b0;
  logic [31:0] addr = '0, store_data = '0, dmem_rdata = '0;
  logic stall, data_valid, access_fault, dmem_req, dmem_we;
  logic [31:0] data_read, dmem_addr, dmem_wdata;
  logic [3:0] dmem_be;
  int n_chk = 0, n_fail = 0;
  logic [31:0] last_dr = '0;
  vec_t sb[$];
  vec_t vecs[16];
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
    .data_read(data_read), .data_valid(data_valid), .access_fault(access_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    vec_t e;
    int stalls;
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr;
    store_data = v.sd; dmem_rdata = v.rdata;
    @(negedge clk);
    chk("access_fault", {31'b0, access_fault}, {31'b0, v.fault});
    if (v.fault) begin
      chk("fault_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("fault_req", {31'b0, dmem_req}, 32'd0);
      chk("fault_data_read", data_read, last_dr);
      return;
    end
    sb.push_back(v);
    stalls = 0;
    for (int c = 0; c <= v.delay + 1; c++) begin
      if (stall) stalls++;
      if (c > 0) begin
        chk("wait_req", {31'b0, dmem_req}, 32'd1);
        chk("wait_we", {31'b0, dmem_we}, {31'b0, v.wr});
        chk("wait_addr", dmem_addr, {v.addr[31:2], 2'b00});
        chk("wait_be", {28'b0, dmem_be}, {28'b0, v.be});
        if (v.wr) chk("wait_wdata", dmem_wdata, v.wdata);
      end
      dmem_ack = (c == v.delay + 1);
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    chk("resp_stall", {31'b0, stall}, 32'd0);
    chk("stall_cycles", stalls, v.delay + 2);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("data_valid", {31'b0, data_valid}, {31'b0, !e.wr});
      if (!e.wr) last_dr = e.dr;
      chk("data_read", data_read, last_dr);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 4'hF, 0, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 1, 0, 4'h8, 0, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 0, 0, 4'h8, 0, 32'h00000080};
    vecs[3]  = '{0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 0, 4'hC, 32'hABCDABCD, 0};
    vecs[4]  = '{1, 0, 3'b001, 32'h102, 0, 32'h80FF0000, 2, 0, 4'hC, 0, 32'hFFFF80FF};
    vecs[5]  = '{1, 0, 3'b101, 32'h100, 0, 32'h1234F00D, 0, 0, 4'h3, 0, 32'h0000F00D};
    vecs[6]  = '{0, 1, 3'b000, 32'h101, 32'h000000A5, 0, 1, 0, 4'h2, 32'hA5A5A5A5, 0};
    vecs[7]  = '{0, 1, 3'b010, 32'h300, 32'hCAFEBABE, 0, 0, 0, 4'hF, 32'hCAFEBABE, 0};
    vecs[8]  = '{1, 0, 3'b000, 32'h101, 0, 32'h11227F33, 0, 0, 4'h2, 0, 32'h0000007F};
    vecs[9]  = '{1, 0, 3'b010, 32'h102, 0, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{1, 0, 3'b011, 32'h100, 0, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 1, 3'b100, 32'h100, 0, 0, 0, 1, 0, 0, 0};
    vecs[12] = '{1, 0, 3'b001, 32'h101, 0, 0, 0, 1, 0, 0, 0};
    vecs[13] = '{1, 1, 3'b010, 32'h400, 32'h11111111, 32'hFFFFFFFF, 0, 0, 4'hF, 32'h11111111, 0};
    vecs[14] = '{1, 0, 3'b110, 32'h100, 0, 0, 0, 1, 0, 0, 0};
    vecs[15] = '{1, 0, 3'b010, 32'h104, 0, 32'h55AA00FF, 5, 0, 4'hF, 0, 32'h55AA00FF};
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_data_read", data_read, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("idle_ack_valid", {31'b0, data_valid}, 32'd0);
    dmem_ack = 1'b0;
    for (int i = 0; i < 16; i++) run(vecs[i]);
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #2;
    chk("mid_req_before_rst", {31'b0, dmem_req}, 32'd1);
    mem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_req_async_drop", {31'b0, dmem_req}, 32'd0);
    @(negedge clk); rst_n = 1'b1; dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("post_rst_valid", {31'b0, data_valid}, 32'd0);
    chk("post_rst_data_read", data_read, 32'd0);
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    chk("post_rst_addr", dmem_addr, 32'd0);
    dmem_ack = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
